// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared fetch-stage constants and their define defaults.
//               The defines are ROM_ADDRESS_BITWIDTH, FETCH_RESET_PC,
//               INST_WIDTH and FETCH_FIFO_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 12
`endif
`ifndef FETCH_RESET_PC
`define FETCH_RESET_PC 0
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef FETCH_FIFO_DEPTH
`define FETCH_FIFO_DEPTH 2
`endif

package fetch_unit_pkg;

    localparam int ROM_AW_DEFAULT   = `ROM_ADDRESS_BITWIDTH;
    localparam int RESET_PC_DEFAULT = `FETCH_RESET_PC;
    localparam int INST_WIDTH       = `INST_WIDTH;
    localparam int FETCH_FIFO_DEPTH = `FETCH_FIFO_DEPTH;
    localparam int CNT_W            = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam int PTR_W            = $clog2(FETCH_FIFO_DEPTH);
    localparam int PC_STEP          = INST_WIDTH / 8;

    function automatic logic is_misaligned(input logic [1:0] i_low_bits);
        return i_low_bits != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
// ============================================================================
// Module      : fetch_skid_fifo
// Description : Small {pc, inst} FIFO absorbing decode back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_fifo
    import fetch_unit_pkg::*;
#(
    parameter int AW = ROM_AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [AW-1:0]         i_push_pc,
    input  logic [INST_WIDTH-1:0] i_push_inst,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count,
    output logic [AW-1:0]         o_head_pc,
    output logic [INST_WIDTH-1:0] o_head_inst
);

    logic [AW-1:0]         r_pc   [FETCH_FIFO_DEPTH];
    logic [INST_WIDTH-1:0] r_inst [FETCH_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Flush has priority so a push in the same cycle is discarded.
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_pc[r_wr_ptr]   <= i_push_pc;
            r_inst[r_wr_ptr] <= i_push_inst;
        end
    end

    assign o_full      = (r_count == CNT_W'(FETCH_FIFO_DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_pc   = r_pc[r_rd_ptr];
    assign o_head_inst = r_inst[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage in front of a 1-cycle-latency ROM.
//               Optional define FETCH_ALIGN_CHECK_EN adds out_fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = ROM_AW_DEFAULT,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [AW-1:0]         rom_addr,
    input  logic [INST_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [AW-1:0]         redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_pc,
    output logic [INST_WIDTH-1:0] out_inst
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  out_fault
`endif
);

    logic [AW-1:0]         r_fetch_pc;
    logic [AW-1:0]         r_inflight_pc;
    logic                  r_inflight_valid;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [AW-1:0]         w_head_pc;
    logic [INST_WIDTH-1:0] w_head_inst;

    logic                  w_fault;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_push;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_issue;
    logic [AW-1:0]         w_redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic                  r_fault;
    logic [AW-1:0]         r_fault_pc;

    // A fault persists until the next redirect; decode pops do not clear it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_fault    <= is_misaligned(redirect_pc[1:0]);
            r_fault_pc <= redirect_pc;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign w_redirect_target = redirect_pc & ~AW'(3);
    assign rom_addr          = r_fetch_pc;

    always_comb begin
        out_valid = r_inflight_valid;
        out_pc    = r_inflight_pc;
        out_inst  = rom_data;
        if (!w_fifo_empty) begin
            out_valid = 1'b1;
            out_pc    = w_head_pc;
            out_inst  = w_head_inst;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        out_fault = r_fault;
        if (r_fault) begin
            out_valid = 1'b1;
            out_pc    = r_fault_pc;
            out_inst  = '0;
        end
`endif
    end

    // The fault word is not a real instruction, so accepting it moves no data.
    assign w_pop    = out_valid & out_ready & ~w_fault;
    assign w_bypass = w_fifo_empty & w_pop & r_inflight_valid;
    assign w_push   = r_inflight_valid & ~w_bypass & ~w_fifo_full;

    assign w_count_next = w_fifo_count + CNT_W'(r_inflight_valid) - CNT_W'(w_pop);
    assign w_issue      = (w_count_next <= CNT_W'(1)) & ~w_fault;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc       <= w_redirect_target;
            r_inflight_valid <= 1'b0;
        end else if (w_issue) begin
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_fetch_pc;
            r_fetch_pc       <= r_fetch_pc + AW'(PC_STEP);
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    fetch_skid_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pop       (w_pop & ~w_fifo_empty),
        .i_flush     (redirect_valid),
        .i_push_pc   (r_inflight_pc),
        .i_push_inst (rom_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (8-bit ROM address space).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_inst;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        out_fault;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rom_mem [64];

    always #5 clk = ~clk;

    fetch_unit #(
        .AW       (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .out_fault      (out_fault)
`endif
    );

    // ROM with one-cycle registered read
    always @(posedge clk) rom_data <= rom_mem[rom_addr[7:2]];

    function automatic logic [31:0] romword(input logic [7:0] a);
        return rom_mem[a[7:2]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference model: decode must see an in-order +4 stream from the last
    // restart point, with bubbles only right after reset or a redirect.
    logic [7:0]  m_next;
    logic        m_fault;
    logic [7:0]  m_fault_pc;
    logic        m_hold;
    logic [7:0]  m_hold_pc;
    logic [31:0] m_hold_inst;
    logic        m_bubble;

    initial begin
        m_next = 8'h00; m_fault = 1'b0; m_fault_pc = 8'h00;
        m_hold = 1'b0; m_hold_pc = 8'h00; m_hold_inst = 32'h0; m_bubble = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_next   = 8'h00;
                m_fault  = 1'b0;
                m_hold   = 1'b0;
                m_bubble = 1'b1;
            end else begin
                chk("m_valid", {31'b0, out_valid}, {31'b0, m_fault | ~m_bubble});
                if (m_fault) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    chk("m_fault_flag", {31'b0, out_fault}, 32'd1);
`endif
                    chk("m_fault_pc", {24'b0, out_pc}, {24'b0, m_fault_pc});
                    chk("m_fault_inst", out_inst, 32'h0);
                end else if (out_valid) begin
                    chk("m_pc", {24'b0, out_pc}, {24'b0, m_next});
                    chk("m_inst", out_inst, romword(m_next));
`ifdef FETCH_ALIGN_CHECK_EN
                    chk("m_nofault", {31'b0, out_fault}, 32'd0);
`endif
                    if (out_ready) m_next = m_next + 8'd4;
                end
                if (m_hold && !m_fault) begin
                    chk("m_stable_pc", {24'b0, out_pc}, {24'b0, m_hold_pc});
                    chk("m_stable_inst", out_inst, m_hold_inst);
                end
                m_hold      = out_valid && !out_ready && !redirect_valid && !m_fault;
                m_hold_pc   = out_pc;
                m_hold_inst = out_inst;
                m_bubble    = 1'b0;
                if (redirect_valid) begin
                    m_fault  = 1'b0;
                    m_next   = redirect_pc & 8'hFC;
                    m_bubble = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        m_fault    = 1'b1;
                        m_fault_pc = redirect_pc;
                        m_bubble   = 1'b0;
                    end
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h5EED_0000 | (i * 4);
        rom_mem[0] = 32'hAAAA_0001;
        rom_mem[1] = 32'hBBBB_0002;
        rom_mem[2] = 32'hCCCC_0003;

        reset_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
        tick(); tick();
        smp();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_addr", {24'b0, rom_addr}, 32'h00);

        // Release and stream A, B, C
        tick(); reset_n = 1'b1;
        smp(); chk("c0_valid", {31'b0, out_valid}, 32'd0);
        tick(); smp();
        chk("c1_valid", {31'b0, out_valid}, 32'd1);
        chk("c1_pc", {24'b0, out_pc}, 32'h00);
        chk("c1_inst", out_inst, 32'hAAAA_0001);
        tick(); smp();
        chk("c2_pc", {24'b0, out_pc}, 32'h04);
        chk("c2_inst", out_inst, 32'hBBBB_0002);
        tick(); smp();
        chk("c3_pc", {24'b0, out_pc}, 32'h08);
        chk("c3_inst", out_inst, 32'hCCCC_0003);

        // Five stalled cycles: two words buffered, address frozen
        tick(); out_ready = 1'b0;
        smp(); chk("st_pc", {24'b0, out_pc}, 32'h0C);
        tick(); smp();
        for (int k = 0; k < 3; k++) begin
            tick(); smp();
            chk("st_addr", {24'b0, rom_addr}, 32'h14);
            chk("st_hold_pc", {24'b0, out_pc}, 32'h0C);
        end
        tick(); out_ready = 1'b1;
        smp(); chk("rs_pc0", {24'b0, out_pc}, 32'h0C);
        tick(); smp(); chk("rs_pc1", {24'b0, out_pc}, 32'h10);
        tick(); smp(); chk("rs_pc2", {24'b0, out_pc}, 32'h14);
        tick(); smp(); chk("rs_pc3", {24'b0, out_pc}, 32'h18);

        // Fill the FIFO again, then redirect to 0x40
        tick(); out_ready = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        smp(); chk("rd_bubble", {31'b0, out_valid}, 32'd0);
        tick(); smp();
        chk("rd_pc0", {24'b0, out_pc}, 32'h40);
        chk("rd_inst0", out_inst, 32'h5EED_0040);
        tick(); smp();
        chk("rd_pc1", {24'b0, out_pc}, 32'h44);

        // Address wrap at the top of the ROM, with a pop in the redirect cycle
        tick(); redirect_valid = 1'b1; redirect_pc = 8'hF8;
        tick(); redirect_valid = 1'b0;
        tick(); smp(); chk("wr_pc0", {24'b0, out_pc}, 32'hF8);
        tick(); smp(); chk("wr_pc1", {24'b0, out_pc}, 32'hFC);
        tick(); smp();
        chk("wr_pc2", {24'b0, out_pc}, 32'h00);
        chk("wr_inst2", out_inst, 32'hAAAA_0001);

        // Misaligned redirect target
        tick(); redirect_valid = 1'b1; redirect_pc = 8'h42;
        tick(); redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("ma_valid", {31'b0, out_valid}, 32'd1);
            chk("ma_fault", {31'b0, out_fault}, 32'd1);
            chk("ma_pc", {24'b0, out_pc}, 32'h42);
            chk("ma_inst", out_inst, 32'h0);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        tick(); redirect_valid = 1'b0;
        smp();
        chk("ma_clr_valid", {31'b0, out_valid}, 32'd0);
        chk("ma_clr_fault", {31'b0, out_fault}, 32'd0);
        tick(); smp();
        chk("ma_clr_pc", {24'b0, out_pc}, 32'h80);
`else
        smp(); chk("ma_bubble", {31'b0, out_valid}, 32'd0);
        tick(); smp();
        chk("ma_pc0", {24'b0, out_pc}, 32'h40);
        chk("ma_inst0", out_inst, 32'h5EED_0040);
        tick(); smp();
        chk("ma_pc1", {24'b0, out_pc}, 32'h44);
`endif

        // Reset pulse with two words buffered
        tick(); out_ready = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick(); reset_n = 1'b1; out_ready = 1'b1;
        smp(); chk("rr_valid", {31'b0, out_valid}, 32'd0);
        tick(); smp();
        chk("rr_pc", {24'b0, out_pc}, 32'h00);
        chk("rr_inst", out_inst, 32'hAAAA_0001);
        tick(); smp();
        chk("rr_pc1", {24'b0, out_pc}, 32'h04);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
